boomerang_ctrl: RTL and testbench

Sequencer for a pair of LED sweep engines (one outbound, one return) that share a single LED bank. It re-arms each engine with a one-cycle local reset and holds `go` until the engine reports `done`. It inserts a programmable pause between legs and repeats the out-and-back trip a requested number of times. It sits between the board-level start/abort controls and the two sweep engine instances, and it owns the LED output mux.

---
 rtl/boomerang_ctrl_if.sv | 40 ++++
 rtl/boomerang_ctrl.sv | 154 +++++++++++++++
 tb/tb_boomerang_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boomerang_ctrl_if.sv
//==============================================================================
// Module   : boomerang_ctrl_if
// Brief    : Control, status and engine-side bundle for boomerang_ctrl.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface boomerang_ctrl_if #(
    parameter int LED_COUNT    = 4,
    parameter int REPEAT_WIDTH = 4
);
    logic                    start;
    logic                    abort;
    logic [REPEAT_WIDTH-1:0] repeats;
    logic                    out_done;
    logic [LED_COUNT-1:0]    out_led;
    logic                    back_done;
    logic [LED_COUNT-1:0]    back_led;
    logic                    out_go;
    logic                    out_rst;
    logic                    back_go;
    logic                    back_rst;
    logic [LED_COUNT-1:0]    led;
    logic                    busy;
    logic                    done;
    logic [REPEAT_WIDTH-1:0] trip_count;

    // master is the sequencer; slave is the board/engine side that feeds it
    modport master (
        input  start, abort, repeats, out_done, out_led, back_done, back_led,
        output out_go, out_rst, back_go, back_rst, led, busy, done, trip_count
    );

    modport slave (
        output start, abort, repeats, out_done, out_led, back_done, back_led,
        input  out_go, out_rst, back_go, back_rst, led, busy, done, trip_count
    );
endinterface

`default_nettype wire

// File: rtl/boomerang_ctrl.sv
//==============================================================================
// Module   : boomerang_ctrl
// Brief    : Out-and-back sequencer for two LED sweep engines sharing one bank.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module boomerang_ctrl #(
    parameter int LED_COUNT    = 4,
    parameter int PAUSE_WIDTH  = 24,
    parameter int PAUSE_CYCLES = 3000000,
    parameter int REPEAT_WIDTH = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    boomerang_ctrl_if.master   bus
);

    localparam logic [PAUSE_WIDTH-1:0]  PAUSE_LOAD = PAUSE_WIDTH'(PAUSE_CYCLES - 1);
    localparam logic [REPEAT_WIDTH-1:0] ONE_TRIP   = REPEAT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM_OUT  = 3'd1,
        S_RUN_OUT  = 3'd2,
        S_PAUSE    = 3'd3,
        S_ARM_BACK = 3'd4,
        S_RUN_BACK = 3'd5,
        S_GAP      = 3'd6,
        S_FINISH   = 3'd7
    } state_t;

    state_t                  state_q, state_d;
    logic [PAUSE_WIDTH-1:0]  pause_q, pause_d;
    logic [REPEAT_WIDTH-1:0] target_q, target_d;
    logic [REPEAT_WIDTH-1:0] trip_q, trip_d;
    logic [REPEAT_WIDTH-1:0] trip_inc;
    logic                    out_go_q, out_go_d;
    logic                    back_go_q, back_go_d;
    logic                    out_strb_q, out_strb_d;
    logic                    back_strb_q, back_strb_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [LED_COUNT-1:0]    led_q, led_d;
    logic                    abort_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pause_q     <= '0;
            target_q    <= ONE_TRIP;
            trip_q      <= '0;
            out_go_q    <= 1'b0;
            back_go_q   <= 1'b0;
            out_strb_q  <= 1'b0;
            back_strb_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            led_q       <= '0;
        end else begin
            state_q     <= state_d;
            pause_q     <= pause_d;
            target_q    <= target_d;
            trip_q      <= trip_d;
            out_go_q    <= out_go_d;
            back_go_q   <= back_go_d;
            out_strb_q  <= out_strb_d;
            back_strb_q <= back_strb_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            led_q       <= led_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pause_d   = pause_q;
        target_d  = target_q;
        trip_d    = trip_q;
        abort_hit = 1'b0;
        trip_inc  = trip_q + ONE_TRIP;

        // abort outranks every other event, including a final back_done
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            abort_hit = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        target_d = (bus.repeats == '0) ? ONE_TRIP : bus.repeats;
                        trip_d   = '0;
                        state_d  = S_ARM_OUT;
                    end
                end
                S_ARM_OUT:  state_d = S_RUN_OUT;
                S_RUN_OUT: begin
                    if (bus.out_done) begin
                        pause_d = PAUSE_LOAD;
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE, S_GAP: begin
                    if (pause_q == '0) begin
                        state_d = (state_q == S_PAUSE) ? S_ARM_BACK : S_ARM_OUT;
                    end else begin
                        pause_d = pause_q - PAUSE_WIDTH'(1);
                    end
                end
                S_ARM_BACK: state_d = S_RUN_BACK;
                S_RUN_BACK: begin
                    if (bus.back_done) begin
                        if (trip_inc >= target_q) begin
                            trip_d  = target_q;
                            state_d = S_FINISH;
                        end else begin
                            trip_d  = trip_inc;
                            pause_d = PAUSE_LOAD;
                            state_d = S_GAP;
                        end
                    end
                end
                S_FINISH:   state_d = S_IDLE;
                default:    state_d = S_IDLE;
            endcase
        end

        // outputs are registered from the next state so they align with it
        out_go_d    = (state_d == S_RUN_OUT);
        back_go_d   = (state_d == S_RUN_BACK);
        out_strb_d  = (state_d == S_ARM_OUT)  || abort_hit;
        back_strb_d = (state_d == S_ARM_BACK) || abort_hit;
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_FINISH);

        case (state_d)
            S_ARM_OUT, S_RUN_OUT, S_PAUSE:            led_d = bus.out_led;
            S_ARM_BACK, S_RUN_BACK, S_GAP, S_FINISH:  led_d = bus.back_led;
            default:                                  led_d = '0;
        endcase
    end

    assign bus.out_go     = out_go_q;
    assign bus.back_go    = back_go_q;
    assign bus.out_rst    = rst | out_strb_q;
    assign bus.back_rst   = rst | back_strb_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.led        = led_q;
    assign bus.trip_count = trip_q;

endmodule

`default_nettype wire

// File: tb/tb_boomerang_ctrl.sv
//==============================================================================
// Module   : tb_boomerang_ctrl
// Brief    : Self-checking bench for boomerang_ctrl with behavioural engines.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_boomerang_ctrl;

    localparam int LED_COUNT    = 4;
    localparam int PAUSE_WIDTH  = 24;
    localparam int PAUSE_CYCLES = 3;
    localparam int REPEAT_WIDTH = 4;
    localparam int RUN_BOUND    = 2000;
    localparam logic [13:0] RESET_VEC = 14'b00_0011_0000_0000;

    logic clk = 1'b0;
    logic rst;

    boomerang_ctrl_if #(.LED_COUNT(LED_COUNT), .REPEAT_WIDTH(REPEAT_WIDTH)) bus();

    boomerang_ctrl #(
        .LED_COUNT   (LED_COUNT),
        .PAUSE_WIDTH (PAUSE_WIDTH),
        .PAUSE_CYCLES(PAUSE_CYCLES),
        .REPEAT_WIDTH(REPEAT_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc_no  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_no);
    endtask

    // Reference model: a run is a queue of timed or event-terminated segments
    typedef struct {
        int len;       // fixed length in cycles, 0 when waiting on an engine
        int wait_eng;  // 1 = outbound done, 2 = return done
        int src;       // 0 none, 1 outbound LEDs, 2 return LEDs
        bit og, bg, orst, brst, dn, inc;
    } seg_t;

    seg_t q[$];
    int   seg_left;
    int   m_trip;
    int   m_target;
    bit   m_abort;
    logic [LED_COUNT-1:0] m_led;

    function automatic seg_t mk(int len, int w, int src, bit og, bit bg,
                                bit orst, bit brst, bit dn, bit inc);
        seg_t s;
        s.len = len; s.wait_eng = w; s.src = src;
        s.og = og; s.bg = bg; s.orst = orst; s.brst = brst; s.dn = dn; s.inc = inc;
        return s;
    endfunction

    task automatic model_reset();
        q.delete();
        m_trip = 0; m_target = 1; m_abort = 1'b0; m_led = '0; seg_left = 0;
    endtask

    task automatic model_build();
        for (int t = 1; t <= m_target; t++) begin
            q.push_back(mk(1,            0, 1, 0, 0, 1, 0, 0, 0));
            q.push_back(mk(0,            1, 1, 1, 0, 0, 0, 0, 0));
            q.push_back(mk(PAUSE_CYCLES, 0, 1, 0, 0, 0, 0, 0, 0));
            q.push_back(mk(1,            0, 2, 0, 0, 0, 1, 0, 0));
            q.push_back(mk(0,            2, 2, 0, 1, 0, 0, 0, 1));
            if (t < m_target) q.push_back(mk(PAUSE_CYCLES, 0, 2, 0, 0, 0, 0, 0, 0));
            else              q.push_back(mk(1,            0, 2, 0, 0, 0, 0, 1, 0));
        end
        seg_left = q[0].len;
    endtask

    // Advance the model across one clock edge using the inputs the DUT samples
    task automatic model_edge();
        bit adv;
        if (rst) begin
            model_reset();
            return;
        end
        m_abort = 1'b0;
        if (q.size() != 0) begin
            if (bus.abort) begin
                q.delete();
                m_abort = 1'b1;
            end else begin
                if (q[0].wait_eng == 1)      adv = bus.out_done;
                else if (q[0].wait_eng == 2) adv = bus.back_done;
                else begin
                    seg_left--;
                    adv = (seg_left == 0);
                end
                if (adv) begin
                    if (q[0].inc) m_trip++;
                    void'(q.pop_front());
                    if (q.size() != 0) seg_left = q[0].len;
                end
            end
        end else if (bus.start && !bus.abort) begin
            m_target = (bus.repeats == '0) ? 1 : int'(bus.repeats);
            m_trip   = 0;
            model_build();
        end
        if (q.size() == 0)    m_led = '0;
        else if (q[0].src == 1) m_led = bus.out_led;
        else                    m_led = bus.back_led;
    endtask

    function automatic logic [13:0] expected_vec();
        bit b, dn, og, bg, orst, brst;
        b = (q.size() != 0);
        dn = 0; og = 0; bg = 0;
        orst = rst | m_abort;
        brst = rst | m_abort;
        if (b) begin
            og = q[0].og; bg = q[0].bg; dn = q[0].dn;
            orst = orst | q[0].orst;
            brst = brst | q[0].brst;
        end
        return {b, dn, og, bg, orst, brst, m_led, REPEAT_WIDTH'(m_trip)};
    endfunction

    function automatic logic [13:0] got_vec();
        return {bus.busy, bus.done, bus.out_go, bus.back_go, bus.out_rst, bus.back_rst,
                bus.led, bus.trip_count};
    endfunction

    // Behavioural sweep engines: done rises a fixed number of go cycles after reset
    int e_cnt [2];
    int e_dly [2];
    bit e_rand = 1'b0;

    task automatic engine_update();
        if (bus.out_rst) begin
            e_cnt[0] = 0; bus.out_done = 1'b0;
            e_dly[0] = e_rand ? int'($urandom_range(1, 7)) : 5;
        end else if (bus.out_go && !bus.out_done) begin
            e_cnt[0]++;
            if (e_cnt[0] >= e_dly[0]) bus.out_done = 1'b1;
        end
        if (bus.back_rst) begin
            e_cnt[1] = 0; bus.back_done = 1'b0;
            e_dly[1] = e_rand ? int'($urandom_range(1, 7)) : 5;
        end else if (bus.back_go && !bus.back_done) begin
            e_cnt[1]++;
            if (e_cnt[1] >= e_dly[1]) bus.back_done = 1'b1;
        end
        bus.out_led  = LED_COUNT'($urandom);
        bus.back_led = LED_COUNT'($urandom);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc_no++;
        chk("outputs{busy,done,out_go,back_go,out_rst,back_rst,led,trip}", got_vec(), expected_vec());
        engine_update();
    endtask

    task automatic finish_run();
        int cyc = 0;
        while (q.size() != 0 && cyc < RUN_BOUND) begin
            step();
            cyc++;
        end
        chk("run bounded", cyc < RUN_BOUND, 1);
    endtask

    typedef struct {
        int rep;       // repeats presented with start
        int mode;      // 0 plain, 1 abort in first RUN_BACK, 2 abort with final back_done, 3 restart in PAUSE
        int exp_trip;
        int exp_done;
    } scen_t;

    scen_t tbl [6];

    task automatic run_scenario(input int idx);
        int cyc   = 0;
        int dones = 0;
        bit fired = 1'b0;
        bit aborting;
        bus.repeats = REPEAT_WIDTH'(tbl[idx].rep);
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
        while (q.size() != 0 && cyc < RUN_BOUND) begin
            case (tbl[idx].mode)
                1: if (!fired && bus.back_go && m_trip == 0) begin bus.abort = 1'b1; fired = 1'b1; end
                2: if (!fired && bus.back_go && bus.back_done) begin bus.abort = 1'b1; fired = 1'b1; end
                3: if (!fired && q[0].src == 1 && q[0].len == PAUSE_CYCLES) begin
                       bus.start = 1'b1; bus.repeats = REPEAT_WIDTH'(5); fired = 1'b1;
                   end
                default: ;
            endcase
            aborting = bus.abort;
            step();
            if (aborting)
                chk("abort response{busy,out_go,back_go,done,out_rst,back_rst,led}",
                    {bus.busy, bus.out_go, bus.back_go, bus.done, bus.out_rst, bus.back_rst, bus.led},
                    10'b0000_11_0000);
            bus.abort = 1'b0;
            bus.start = 1'b0;
            if (bus.done) dones++;
            cyc++;
        end
        chk("scenario bounded", cyc < RUN_BOUND, 1);
        chk("final trip_count", bus.trip_count, tbl[idx].exp_trip);
        chk("done pulses", dones, tbl[idx].exp_done);
        chk("busy falls", bus.busy, 0);
        step();
        step();
    endtask

    initial begin
        tbl[0] = '{2,  0, 2,  1};
        tbl[1] = '{0,  0, 1,  1};
        tbl[2] = '{3,  1, 0,  0};
        tbl[3] = '{2,  3, 2,  1};
        tbl[4] = '{1,  2, 0,  0};
        tbl[5] = '{15, 0, 15, 1};

        rst = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.repeats = '0;
        bus.out_done = 1'b0; bus.back_done = 1'b0;
        bus.out_led = '0; bus.back_led = '0;
        e_cnt[0] = 0; e_cnt[1] = 0; e_dly[0] = 5; e_dly[1] = 5;
        model_reset();
        #1;
        chk("reset values", got_vec(), RESET_VEC);
        step();
        step();
        rst = 1'b0;
        step();

        // start latency: busy/out_rst one edge after start, out_go one edge later
        bus.repeats = REPEAT_WIDTH'(1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("start -> {busy,out_rst,out_go}", {bus.busy, bus.out_rst, bus.out_go}, 3'b110);
        step();
        chk("start+2 -> {busy,out_rst,out_go}", {bus.busy, bus.out_rst, bus.out_go}, 3'b101);
        finish_run();
        step();

        // abort together with start in IDLE keeps the block idle
        bus.start = 1'b1; bus.abort = 1'b1;
        step();
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("abort with start in IDLE", bus.busy, 0);
        step();

        for (int i = 0; i < 6; i++) run_scenario(i);

        // asynchronous reset in the middle of the outbound leg
        begin
            int cyc = 0;
            bus.repeats = REPEAT_WIDTH'(3);
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            while (!bus.out_go && cyc < 20) begin step(); cyc++; end
            chk("reached RUN_OUT", bus.out_go, 1);
            step();
            step();
            rst = 1'b1;
            #1;
            model_reset();
            chk("async reset mid-run", got_vec(), RESET_VEC);
            engine_update();
            step();
            chk("held in reset", got_vec(), RESET_VEC);
            rst = 1'b0;
            step();
            run_scenario(0);
        end

        // randomized runs with noisy start/abort and variable engine latency
        e_rand = 1'b1;
        for (int r = 0; r < 10; r++) begin
            int cyc = 0;
            bus.repeats = REPEAT_WIDTH'($urandom_range(0, 4));
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            while (q.size() != 0 && cyc < RUN_BOUND) begin
                bus.abort   = ($urandom_range(0, 59) == 0);
                bus.start   = ($urandom_range(0, 9) == 0);
                bus.repeats = REPEAT_WIDTH'($urandom);
                step();
                cyc++;
            end
            bus.abort = 1'b0;
            bus.start = 1'b0;
            chk("random run bounded", cyc < RUN_BOUND, 1);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
